mem_responder: RTL

Memory-side responder for the multicycle core's three memory ports: instruction fetch, load and store. It serves all three from one single-port synchronous RAM. Stores are absorbed into a small store buffer and drained into the RAM when the RAM port is free. Loads that hit a buffered store are forwarded from the buffer. Fetch and load completion is signalled by one-cycle valid pulses, so the core's stage counter can extend a stage when the response is late.

---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Signal bundle between the core's fetch/load/store ports, mem_responder and the single-port RAM.
interface mem_responder_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 16
);
  logic          pc_en;
  logic [W-1:0]  pc;
  logic [W-1:0]  read_inst;
  logic          inst_valid;
  logic          load_en;
  logic [W-1:0]  l_addr;
  logic [W-1:0]  l_data;
  logic          l_valid;
  logic          store_en;
  logic [W-1:0]  s_addr;
  logic [W-1:0]  s_data;
  logic          sb_full;
  logic          sb_empty;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;

  modport slave (
    input  pc_en, pc, load_en, l_addr, store_en, s_addr, s_data, ram_rdata,
    output read_inst, inst_valid, l_data, l_valid, sb_full, sb_empty,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output pc_en, pc, load_en, l_addr, store_en, s_addr, s_data, ram_rdata,
    input  read_inst, inst_valid, l_data, l_valid, sb_full, sb_empty,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_responder.sv
// Serves fetch, load and store ports from one single-port synchronous RAM,
// with a store buffer that forwards to loads and drains when the RAM is free.
module mem_responder #(
  parameter int unsigned W        = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    G_IDLE,
    G_DRAIN,
    G_FETCH,
    G_LOAD
  } grant_e;

  logic [AW-1:0] sb_addr_q [SB_DEPTH];
  logic [W-1:0]  sb_data_q [SB_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          fp_valid_q, fp_valid_d;
  logic [AW-1:0] fp_addr_q, fp_addr_d;
  logic          lp_valid_q, lp_valid_d;
  logic [AW-1:0] lp_addr_q, lp_addr_d;

  logic          resp_fetch_q, resp_fetch_d;
  logic          resp_load_q, resp_load_d;
  logic          fwd_valid_q, fwd_valid_d;
  logic [W-1:0]  inst_q, inst_d;
  logic [W-1:0]  ldata_q, ldata_d;

  logic [AW-1:0] pc_waddr, l_waddr, s_waddr;
  logic          fetch_req, load_req;
  logic [AW-1:0] fetch_waddr, load_waddr;
  logic          fwd_hit, load_hit;
  logic [W-1:0]  fwd_data;
  logic [PW-1:0] fwd_idx;
  logic          sb_is_full, drain;
  grant_e        grant;

  logic          ram_en_c, ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [W-1:0]  ram_wdata_c;

  logic          unused_addr_bits;

  assign pc_waddr = bus.pc[AW+1:2];
  assign l_waddr  = bus.l_addr[AW+1:2];
  assign s_waddr  = bus.s_addr[AW+1:2];
  assign unused_addr_bits = ^{bus.pc[W-1:AW+2], bus.pc[1:0],
                              bus.l_addr[W-1:AW+2], bus.l_addr[1:0],
                              bus.s_addr[W-1:AW+2], bus.s_addr[1:0]};

  // A pending request is older than a new strobe of the same type, so it goes first.
  assign fetch_req   = fp_valid_q | bus.pc_en;
  assign fetch_waddr = fp_valid_q ? fp_addr_q : pc_waddr;
  assign load_req    = lp_valid_q | bus.load_en;
  assign load_waddr  = lp_valid_q ? lp_addr_q : l_waddr;
  assign sb_is_full  = (count_q == CW'(SB_DEPTH));

  // Youngest-match search: walk oldest to youngest, then the store arriving now.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_addr_q[fwd_idx] == load_waddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[fwd_idx];
      end
    end
    if (bus.store_en && (s_waddr == load_waddr)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.s_data;
    end
  end

  assign load_hit = load_req & fwd_hit;

  // One RAM grant per cycle in strict priority order.
  always_comb begin
    grant = G_IDLE;
    if (sb_is_full) begin
      grant = G_DRAIN;
    end else if (fetch_req) begin
      grant = G_FETCH;
    end else if (load_req && !fwd_hit) begin
      grant = G_LOAD;
    end else if (count_q != '0) begin
      grant = G_DRAIN;
    end
  end

  assign drain = (grant == G_DRAIN);

  // RAM command for the granted requester.
  always_comb begin
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    case (grant)
      G_DRAIN: begin
        ram_en_c    = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = sb_addr_q[rd_ptr_q];
        ram_wdata_c = sb_data_q[rd_ptr_q];
      end
      G_FETCH: begin
        ram_en_c   = 1'b1;
        ram_addr_c = fetch_waddr;
      end
      G_LOAD: begin
        ram_en_c   = 1'b1;
        ram_addr_c = load_waddr;
      end
      default: ;
    endcase
  end

  // Next state for pending registers, response steering, held data and buffer pointers.
  always_comb begin
    fp_valid_d   = fp_valid_q;
    fp_addr_d    = fp_addr_q;
    lp_valid_d   = lp_valid_q;
    lp_addr_d    = lp_addr_q;
    resp_fetch_d = (grant == G_FETCH);
    resp_load_d  = (grant == G_LOAD);
    fwd_valid_d  = load_hit;
    inst_d       = inst_q;
    ldata_d      = ldata_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CW'(bus.store_en) - CW'(drain);

    if (fetch_req) begin
      if (grant == G_FETCH) begin
        fp_valid_d = fp_valid_q & bus.pc_en;
        fp_addr_d  = pc_waddr;
      end else begin
        fp_valid_d = 1'b1;
        fp_addr_d  = bus.pc_en ? pc_waddr : fp_addr_q;
      end
    end

    if (load_req) begin
      if ((grant == G_LOAD) || load_hit) begin
        lp_valid_d = lp_valid_q & bus.load_en;
        lp_addr_d  = l_waddr;
      end else begin
        lp_valid_d = 1'b1;
        lp_addr_d  = bus.load_en ? l_waddr : lp_addr_q;
      end
    end

    if (resp_fetch_q) inst_d  = bus.ram_rdata;
    if (resp_load_q)  ldata_d = bus.ram_rdata;
    if (load_hit)     ldata_d = fwd_data;

    if (drain)        rd_ptr_d = rd_ptr_q + PW'(1);
    if (bus.store_en) wr_ptr_d = wr_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fp_valid_q   <= 1'b0;
      fp_addr_q    <= '0;
      lp_valid_q   <= 1'b0;
      lp_addr_q    <= '0;
      resp_fetch_q <= 1'b0;
      resp_load_q  <= 1'b0;
      fwd_valid_q  <= 1'b0;
      inst_q       <= '0;
      ldata_q      <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fp_valid_q   <= fp_valid_d;
      fp_addr_q    <= fp_addr_d;
      lp_valid_q   <= lp_valid_d;
      lp_addr_q    <= lp_addr_d;
      resp_fetch_q <= resp_fetch_d;
      resp_load_q  <= resp_load_d;
      fwd_valid_q  <= fwd_valid_d;
      inst_q       <= inst_d;
      ldata_q      <= ldata_d;
    end
  end

  // Entry storage needs no reset: the count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (bus.store_en) begin
      sb_addr_q[wr_ptr_q] <= s_waddr;
      sb_data_q[wr_ptr_q] <= bus.s_data;
    end
  end

  // RAM read data is steered straight through in the response cycle, else the last value is held.
  assign bus.read_inst  = resp_fetch_q ? bus.ram_rdata : inst_q;
  assign bus.inst_valid = resp_fetch_q;
  assign bus.l_data     = resp_load_q ? bus.ram_rdata : ldata_q;
  assign bus.l_valid    = resp_load_q | fwd_valid_q;
  assign bus.sb_full    = sb_is_full;
  assign bus.sb_empty   = (count_q == '0);
  assign bus.ram_en     = ram_en_c;
  assign bus.ram_we     = ram_we_c;
  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;

endmodule
